// File: rtl/clock_pkg.sv
// Shared types and defaults for the key-panel front end.
package clock_pkg;
  localparam int N_BTN_DFLT = 12;

  // Width helper that never returns 0, so 1-key or 1-cycle builds still elaborate.
  function automatic int cw(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  localparam int KEY_W = cw(N_BTN_DFLT);

  typedef enum logic [1:0] {IDLE, DELAY, REPEAT} rpt_state_t;
endpackage

// File: rtl/button_conditioner_if.sv
// Key panel bus: raw keys in, conditioned level/pulse/code out.
interface button_conditioner_if
  import clock_pkg::*;
#(
  parameter int N_BTN = N_BTN_DFLT
) ();
  localparam int KW = cw(N_BTN);

  logic [N_BTN-1:0] button_raw;
  logic [N_BTN-1:0] button_level;
  logic [N_BTN-1:0] button_pulse;
  logic             key_valid;
  logic [KW-1:0]    key_code;

  modport master (output button_raw,
                  input  button_level, button_pulse, key_valid, key_code);
  modport slave  (input  button_raw,
                  output button_level, button_pulse, key_valid, key_code);
endinterface

// File: rtl/button_conditioner_debounce_bit.sv
// One key: 2-FF synchroniser, stability counter and accepted level.
module debounce_bit
  import clock_pkg::*;
#(
  parameter int DB_CYCLES = 100_000
) (
  input  logic clock,
  input  logic reset,
  input  logic raw,
  output logic level,
  output logic level_next
);
  localparam int CW = cw(DB_CYCLES);

  logic          sync1, sync2;
  logic [CW-1:0] cnt;
  logic          term;

  assign term = (sync2 != level) && (cnt == CW'(DB_CYCLES - 1));
  // Exposed so the top can register the press pulse alongside the level flop.
  assign level_next = term ? sync2 : level;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      sync1 <= 1'b0;
      sync2 <= 1'b0;
      cnt   <= '0;
      level <= 1'b0;
    end else begin
      sync1 <= raw;
      sync2 <= sync1;
      level <= level_next;
      if (sync2 == level || term) cnt <= '0;
      else                        cnt <= cnt + CW'(1);
    end
  end
endmodule

// File: rtl/button_conditioner.sv
// Debounced key levels, press/auto-repeat pulses and lowest-index key code.
module button_conditioner
  import clock_pkg::*;
#(
  parameter int N_BTN        = N_BTN_DFLT,
  parameter int DB_CYCLES    = 100_000,
  parameter int REPEAT_DELAY = 50_000_000,
  parameter int REPEAT_RATE  = 10_000_000
) (
  input logic                 clock,
  input logic                 reset,
  button_conditioner_if.slave bus
);
  localparam int KW = cw(N_BTN);
  localparam int TW = cw((REPEAT_DELAY > REPEAT_RATE) ? REPEAT_DELAY : REPEAT_RATE);

  logic [N_BTN-1:0] level, level_next, rise, rpt, pulse_next;
  logic [N_BTN-1:0] pulse_q;
  logic             valid_q;
  logic [KW-1:0]    code_q;

  rpt_state_t    state_q, state_d;
  logic [KW-1:0] trk_q, trk_d;
  logic [TW-1:0] tmr_q, tmr_d;
  logic          tc;

  function automatic logic [KW-1:0] lowest(input logic [N_BTN-1:0] v);
    lowest = '0;
    for (int i = N_BTN - 1; i >= 0; i--)
      if (v[i]) lowest = KW'(i);
  endfunction

  for (genvar i = 0; i < N_BTN; i++) begin : g_db
    debounce_bit #(.DB_CYCLES(DB_CYCLES)) u_db (
      .clock      (clock),
      .reset      (reset),
      .raw        (bus.button_raw[i]),
      .level      (level[i]),
      .level_next (level_next[i])
    );
  end

  assign rise = level_next & ~level;
  assign tc   = (state_q == DELAY) ? (tmr_q == TW'(REPEAT_DELAY - 1))
                                   : (tmr_q == TW'(REPEAT_RATE - 1));

  // Release of the tracked key beats a retarget, which beats the repeat tick.
  always_comb begin
    state_d = state_q;
    trk_d   = trk_q;
    tmr_d   = tmr_q;
    rpt     = '0;
    case (state_q)
      IDLE: if (|rise) begin
        trk_d   = lowest(rise);
        tmr_d   = '0;
        state_d = DELAY;
      end
      DELAY, REPEAT: begin
        if (!level_next[trk_q]) begin
          tmr_d   = '0;
          state_d = IDLE;
        end else if (|rise) begin
          trk_d   = lowest(rise);
          tmr_d   = '0;
          state_d = DELAY;
        end else if (tc) begin
          rpt[trk_q] = 1'b1;
          tmr_d      = '0;
          state_d    = REPEAT;
        end else begin
          tmr_d = tmr_q + TW'(1);
        end
      end
      default: begin
        tmr_d   = '0;
        state_d = IDLE;
      end
    endcase
  end

  assign pulse_next = rise | rpt;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      trk_q   <= '0;
      tmr_q   <= '0;
      pulse_q <= '0;
      valid_q <= 1'b0;
      code_q  <= '0;
    end else begin
      state_q <= state_d;
      trk_q   <= trk_d;
      tmr_q   <= tmr_d;
      pulse_q <= pulse_next;
      valid_q <= |pulse_next;
      code_q  <= lowest(pulse_next);
    end
  end

  assign bus.button_level = level;
  assign bus.button_pulse = pulse_q;
  assign bus.key_valid    = valid_q;
  assign bus.key_code     = code_q;
endmodule

// File: tb/tb_button_conditioner.sv
// Scoreboarded bench: expected pulse events queued at stimulus time, matched as the DUT emits them.
module tb_button_conditioner;
  import clock_pkg::*;

  localparam int DB = 4;
  localparam int RD = 20;
  localparam int RR = 8;

  typedef struct {
    logic [11:0]      pulse;
    logic [KEY_W-1:0] code;
    bit               rel;
    int               lo;
    int               hi;
    int               delta;
  } exp_t;

  logic clock = 1'b0;
  logic reset = 1'b1;
  int   cyc = 0;
  int   checks = 0;
  int   errors = 0;
  int   last_cyc = 0;
  exp_t sb[$];

  button_conditioner_if #(.N_BTN(12)) bus ();

  button_conditioner #(
    .N_BTN(12), .DB_CYCLES(DB), .REPEAT_DELAY(RD), .REPEAT_RATE(RR)
  ) dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus.slave)
  );

  always #5 clock = ~clock;
  always @(posedge clock) cyc <= cyc + 1;

  task automatic tick(input int n);
    repeat (n) @(negedge clock);
  endtask

  // Press expected DB+2 clocks after the raw edge, allowing one clock either way.
  task automatic push_abs(input logic [11:0] p, input int c, input int t0);
    exp_t e;
    e.pulse = p; e.code = KEY_W'(c); e.rel = 1'b0;
    e.lo = t0 + DB + 1; e.hi = t0 + DB + 3; e.delta = 0;
    sb.push_back(e);
  endtask

  // Repeat expected exactly delta clocks after the previous observed event.
  task automatic push_rel(input logic [11:0] p, input int c, input int d);
    exp_t e;
    e.pulse = p; e.code = KEY_W'(c); e.rel = 1'b1;
    e.lo = 0; e.hi = 0; e.delta = d;
    sb.push_back(e);
  endtask

  task automatic monitor();
    exp_t e;
    int   lo, hi;
    forever begin
      @(negedge clock);
      if (!reset && (bus.button_pulse != '0 || bus.key_valid)) begin
        checks++;
        if (sb.size() == 0) begin
          errors++;
          $display("FAIL unexpected_event cyc=%0d pulse=%h valid=%b code=%0d",
                   cyc, bus.button_pulse, bus.key_valid, bus.key_code);
        end else begin
          e  = sb.pop_front();
          lo = e.rel ? last_cyc + e.delta : e.lo;
          hi = e.rel ? last_cyc + e.delta : e.hi;
          if (cyc < lo || cyc > hi || bus.button_pulse !== e.pulse ||
              bus.key_valid !== 1'b1 || bus.key_code !== e.code) begin
            errors++;
            $display("FAIL event cyc=%0d want=[%0d,%0d] pulse=%h want=%h valid=%b code=%0d want=%0d",
                     cyc, lo, hi, bus.button_pulse, e.pulse, bus.key_valid, bus.key_code, e.code);
          end
        end
        last_cyc = cyc;
      end
    end
  endtask

  task automatic check_drained(input string name);
    checks++;
    if (sb.size() !== 0) begin
      errors++;
      $display("FAIL %s_missing_events got=%0d left want=0", name, sb.size());
      sb.delete();
    end
  endtask

  task automatic check_outputs_zero(input string name);
    checks++;
    if (bus.button_level !== '0 || bus.button_pulse !== '0 ||
        bus.key_valid !== 1'b0 || bus.key_code !== '0) begin
      errors++;
      $display("FAIL %s got level=%h pulse=%h valid=%b code=%0d want all 0",
               name, bus.button_level, bus.button_pulse, bus.key_valid, bus.key_code);
    end
  endtask

  task automatic test_reset();
    int t0;
    bus.button_raw = 12'hFFF;
    tick(4);
    check_outputs_zero("reset_hold");
    reset = 1'b0;
    t0 = cyc;
    push_abs(12'hFFF, 0, t0);
    tick(8);
    checks++;
    if (bus.button_level !== 12'hFFF) begin
      errors++;
      $display("FAIL reset_release_level got=%h want=fff", bus.button_level);
    end
    bus.button_raw = 12'h000;
    tick(12);
    checks++;
    if (bus.button_level !== 12'h000) begin
      errors++;
      $display("FAIL release_level got=%h want=000", bus.button_level);
    end
    tick(20);
    check_drained("reset");
  endtask

  task automatic test_bounce();
    int t0;
    for (int k = 0; k < 6; k++) begin
      bus.button_raw[3] = ~k[0];
      tick(2);
    end
    checks++;
    if (bus.button_level[3] !== 1'b0) begin
      errors++;
      $display("FAIL bounce_level_glitch got=%b want=0", bus.button_level[3]);
    end
    bus.button_raw[3] = 1'b1;
    t0 = cyc;
    push_abs(12'h008, 3, t0);
    tick(10);
    checks++;
    if (bus.button_level[3] !== 1'b1) begin
      errors++;
      $display("FAIL bounce_level_settled got=%b want=1", bus.button_level[3]);
    end
    bus.button_raw[3] = 1'b0;
    tick(30);
    check_drained("bounce");
  endtask

  task automatic test_repeat();
    push_abs(12'h020, 5, cyc);
    push_rel(12'h020, 5, RD);
    for (int k = 0; k < 6; k++) push_rel(12'h020, 5, RR);
    bus.button_raw[5] = 1'b1;
    tick(70);
    bus.button_raw[5] = 1'b0;
    tick(30);
    check_drained("repeat");
  endtask

  task automatic test_simultaneous();
    push_abs(12'h084, 2, cyc);
    push_rel(12'h004, 2, RD);
    push_rel(12'h004, 2, RR);
    push_rel(12'h004, 2, RR);
    bus.button_raw[2] = 1'b1;
    bus.button_raw[7] = 1'b1;
    tick(40);
    bus.button_raw[2] = 1'b0;
    bus.button_raw[7] = 1'b0;
    tick(30);
    check_drained("simultaneous");
  endtask

  task automatic test_retarget();
    push_abs(12'h002, 1, cyc);
    bus.button_raw[1] = 1'b1;
    tick(10);
    bus.button_raw[1] = 1'b0;
    tick(30);
    check_drained("release_in_delay");
    push_abs(12'h002, 1, cyc);
    push_rel(12'h002, 1, RD);
    push_rel(12'h002, 1, RR);
    bus.button_raw[1] = 1'b1;
    tick(32);
    push_abs(12'h200, 9, cyc);
    push_rel(12'h200, 9, RD);
    push_rel(12'h200, 9, RR);
    bus.button_raw[9] = 1'b1;
    tick(32);
    bus.button_raw[1] = 1'b0;
    bus.button_raw[9] = 1'b0;
    tick(30);
    check_drained("retarget");
  endtask

  task automatic test_reset_mid();
    push_abs(12'h010, 4, cyc);
    push_rel(12'h010, 4, RD);
    push_rel(12'h010, 4, RR);
    bus.button_raw[4] = 1'b1;
    tick(36);
    check_drained("pre_reset");
    #2 reset = 1'b1;
    #1 check_outputs_zero("async_reset");
    tick(3);
    reset = 1'b0;
    push_abs(12'h010, 4, cyc);
    push_rel(12'h010, 4, RD);
    push_rel(12'h010, 4, RR);
    tick(30);
    bus.button_raw[4] = 1'b0;
    tick(30);
    check_drained("reset_mid");
  endtask

  initial begin
    bus.button_raw = '0;
    fork
      monitor();
    join_none
    test_reset();
    test_bounce();
    test_repeat();
    test_simultaneous();
    test_retarget();
    test_reset_mid();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog_timeout cyc=%0d want finish before 20000 cycles", cyc);
    $fatal(1, "watchdog");
  end
endmodule
